// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Tracks in-flight register writers in the post-decode stages (1 = E ..
//   DEPTH = W). It raises a stall when a decode operand is needed before its
//   producer can supply it, and selects the youngest forwarding stage for each
//   decode source operand.
//
//   Optional multiply/divide busy tracking: define HAZARD_SCOREBOARD_MDU_EN.
//   Without it, md_start/md_div/uses_md_d are ignored, md_busy is tied to 0,
//   and no counter is built.
//
// Ports
//   clk, reset_n              clock, async active-low reset
//   valid_d                   decode holds a real instruction
//   rs_d, rt_d                decode source registers
//   tuse_rs, tuse_rt          cycles until operand use (3 = unused)
//   res_d                     result class (0 nw, 1 alu, 2 dm, 3 pc, 4 other)
//   dst_d                     decode destination register
//   flush                     drop every in-flight entry
//   md_start, md_div          MDU issue / issue is a divide
//   uses_md_d                 decode instruction needs the MDU or hi/lo
//   stall                     freeze F/D, bubble into E (combinational)
//   fwd_rs_sel, fwd_rt_sel    0 = register file, k = stage k (combinational)
//   md_busy                   MDU occupied
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned TNEW_W = 2,
    localparam int unsigned SELW  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_d,
    input  logic [4:0]      rs_d,
    input  logic [4:0]      rt_d,
    input  logic [1:0]      tuse_rs,
    input  logic [1:0]      tuse_rt,
    input  logic [2:0]      res_d,
    input  logic [4:0]      dst_d,
    input  logic            flush,
    input  logic            md_start,
    input  logic            md_div,
    input  logic            uses_md_d,
    output logic            stall,
    output logic [SELW-1:0] fwd_rs_sel,
    output logic [SELW-1:0] fwd_rt_sel,
    output logic            md_busy
);

    localparam int unsigned CMPW = (TNEW_W > 2) ? TNEW_W : 2;

    localparam logic [2:0] RES_ALU   = 3'd1;
    localparam logic [2:0] RES_DM    = 3'd2;
    localparam logic [2:0] RES_PC    = 3'd3;
    localparam logic [2:0] RES_OTHER = 3'd4;

    logic              ent_v    [1:DEPTH];
    logic [4:0]        ent_dst  [1:DEPTH];
    logic [TNEW_W-1:0] ent_tnew [1:DEPTH];

    logic              ins_writes;
    logic [TNEW_W-1:0] ins_tnew;
    logic              raw_hazard;
    logic              md_hazard;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // Result class -> whether it writes a register and its initial tnew
    always_comb begin
        ins_writes = 1'b0;
        ins_tnew   = '0;
        case (res_d)
            RES_ALU: begin
                ins_writes = 1'b1;
                ins_tnew   = TNEW_W'(1);
            end
            RES_DM: begin
                ins_writes = 1'b1;
                ins_tnew   = TNEW_W'(2);
            end
            RES_PC, RES_OTHER: ins_writes = 1'b1;
            default: ;
        endcase
    end

    // Walk oldest to youngest so the youngest match is left in the select
    always_comb begin
        raw_hazard = 1'b0;
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            if (ent_v[k] && (rs_d != 5'd0) && (ent_dst[k] == rs_d)) begin
                fwd_rs_sel = SELW'(k);
                if ((tuse_rs != 2'd3) && (CMPW'(ent_tnew[k]) > CMPW'(tuse_rs)))
                    raw_hazard = 1'b1;
            end
            if (ent_v[k] && (rt_d != 5'd0) && (ent_dst[k] == rt_d)) begin
                fwd_rt_sel = SELW'(k);
                if ((tuse_rt != 2'd3) && (CMPW'(ent_tnew[k]) > CMPW'(tuse_rt)))
                    raw_hazard = 1'b1;
            end
        end
    end

    // reset_n gating keeps stall low even while MDU inputs are active in reset
    assign stall = reset_n && !flush && valid_d && (raw_hazard || md_hazard);

    // Shift entries down the pipe; E takes the decode writer or a bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                ent_v[k]    <= 1'b0;
                ent_dst[k]  <= 5'd0;
                ent_tnew[k] <= '0;
            end
        end else begin
            for (int k = int'(DEPTH); k >= 2; k--) begin
                ent_v[k]    <= ent_v[k-1] && !flush;
                ent_dst[k]  <= ent_dst[k-1];
                ent_tnew[k] <= sat_dec(ent_tnew[k-1]);
            end
            ent_v[1]    <= valid_d && ins_writes && (dst_d != 5'd0) && !stall && !flush;
            ent_dst[1]  <= dst_d;
            ent_tnew[1] <= ins_tnew;
        end
    end

`ifdef HAZARD_SCOREBOARD_MDU_EN
    logic [3:0] md_count;

    // Busy countdown; a new issue always reloads, flush leaves it running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_count <= 4'd0;
        end else if (md_start) begin
            md_count <= md_div ? 4'd10 : 4'd5;
        end else if (md_count != 4'd0) begin
            md_count <= md_count - 4'd1;
        end
    end

    assign md_busy   = (md_count != 4'd0);
    assign md_hazard = uses_md_d && (md_busy || md_start);
`else
    logic unused_md;
    assign unused_md = ^{md_start, md_div, uses_md_d};
    assign md_busy   = 1'b0;
    assign md_hazard = 1'b0;
`endif

endmodule
